sram_controller: RTL and testbench

- Sequences 32-bit MEM-stage loads/stores onto the 16-bit external SRAM (SRAM_DQ/SRAM_ADDR/SRAM_WE_N interface).
- Splits each word access into low/high half-word phases with programmable wait states.
- Drives `ready` low to freeze the ARM pipeline while an access is in flight.
- Sits between the ARM MEM stage and the top-level SRAM pins.

---
 rtl/arm_mem_pkg.sv | 24 ++
 rtl/sram_wait_counter.sv | 27 ++
 rtl/sram_controller.sv | 187 ++++++++++++++++++
 tb/tb_sram_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM MEM-stage to external SRAM bridge.
package arm_mem_pkg;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WORD_W      = 32;
  localparam int WORD_IDX_W  = SRAM_ADDR_W - 1;

  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sram_state_t;

  // Byte address to SRAM word index; wraps silently outside the mapped window.
  function automatic logic [WORD_IDX_W-1:0] word_index(
    input logic [WORD_W-1:0] address,
    input logic [WORD_W-1:0] base
  );
    return WORD_IDX_W'((address - base) >> 2);
  endfunction
endpackage

// File: rtl/sram_wait_counter.sv
// Load/decrement wait-state counter; tc flags the last cycle of a bus phase.
module sram_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);
  logic [WIDTH-1:0] count_r;

  // Reload at phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == {WIDTH{1'b0}});
endmodule

// File: rtl/sram_controller.sv
// 32-bit MEM-stage load/store sequencer for a 16-bit async SRAM (low then high half).
// Optional performance counters are enabled with `define SRAM_CTRL_PERF_CNT_EN.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
`ifdef SRAM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] stall_count
`endif
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  sram_state_t             state_r, state_next_s;
  logic                    op_wr_r, op_wr_next_s;
  logic [WORD_IDX_W-1:0]   word_r, word_next_s;
  logic [WORD_W-1:0]       wdata_r, wdata_next_s;
  logic [WORD_W-1:0]       rd_data_r;
  logic [SRAM_ADDR_W-1:0]  sram_addr_r, sram_addr_next_s;
  logic                    we_n_r, we_n_next_s;
  logic                    dq_oe_r, dq_oe_next_s;
  logic [SRAM_DATA_W-1:0]  dq_out_r, dq_out_next_s;
  logic                    cnt_load_s, cnt_tc_s, ready_s, req_s;

  assign req_s = rd_en | wr_en;

  sram_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load_s),
    .load_value (CNT_LOAD),
    .tc         (cnt_tc_s)
  );

  // Next-state, request capture and ready generation.
  always_comb begin
    state_next_s = state_r;
    op_wr_next_s = op_wr_r;
    word_next_s  = word_r;
    wdata_next_s = wdata_r;
    cnt_load_s   = 1'b0;
    ready_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = ~req_s;
        if (req_s) begin
          state_next_s = ST_LOW;
          op_wr_next_s = wr_en;
          word_next_s  = word_index(address, BASE_ADDR);
          wdata_next_s = wr_data;
          cnt_load_s   = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (cnt_tc_s) begin
          state_next_s = ST_HIGH;
          cnt_load_s   = 1'b1;
        end else begin
          state_next_s = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (cnt_tc_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_HIGH;
        end
      end
      ST_DONE: begin
        ready_s      = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        ready_s      = 1'b1;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Bus pins are registered, so derive their values from the state being entered.
  always_comb begin
    sram_addr_next_s = sram_addr_r;
    we_n_next_s      = 1'b1;
    dq_oe_next_s     = 1'b0;
    dq_out_next_s    = dq_out_r;
    case (state_next_s)
      ST_LOW: begin
        sram_addr_next_s = {word_next_s, 1'b0};
        we_n_next_s      = ~op_wr_next_s;
        dq_oe_next_s     = op_wr_next_s;
        dq_out_next_s    = wdata_next_s[15:0];
      end
      ST_HIGH: begin
        sram_addr_next_s = {word_next_s, 1'b1};
        we_n_next_s      = ~op_wr_next_s;
        dq_oe_next_s     = op_wr_next_s;
        dq_out_next_s    = wdata_next_s[31:16];
      end
      default: begin
        sram_addr_next_s = sram_addr_r;
      end
    endcase
  end

  // State, captured request and registered bus drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      op_wr_r     <= 1'b0;
      word_r      <= {WORD_IDX_W{1'b0}};
      wdata_r     <= {WORD_W{1'b0}};
      sram_addr_r <= {SRAM_ADDR_W{1'b0}};
      we_n_r      <= 1'b1;
      dq_oe_r     <= 1'b0;
      dq_out_r    <= {SRAM_DATA_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      op_wr_r     <= op_wr_next_s;
      word_r      <= word_next_s;
      wdata_r     <= wdata_next_s;
      sram_addr_r <= sram_addr_next_s;
      we_n_r      <= we_n_next_s;
      dq_oe_r     <= dq_oe_next_s;
      dq_out_r    <= dq_out_next_s;
    end
  end

  // Read halves are captured on the final wait cycle of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {WORD_W{1'b0}};
    end else if ((state_r == ST_LOW) && cnt_tc_s && !op_wr_r) begin
      rd_data_r[15:0] <= SRAM_DQ;
    end else if ((state_r == ST_HIGH) && cnt_tc_s && !op_wr_r) begin
      rd_data_r[31:16] <= SRAM_DQ;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

`ifdef SRAM_CTRL_PERF_CNT_EN
  // Access and stall statistics, free-running modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count    <= 32'd0;
      wr_count    <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      rd_count    <= rd_count + {31'd0, (state_r == ST_DONE) && !op_wr_r};
      wr_count    <= wr_count + {31'd0, (state_r == ST_DONE) && op_wr_r};
      stall_count <= stall_count + {31'd0, !ready_s};
    end
  end
`endif

  assign SRAM_DQ   = dq_oe_r ? dq_out_r : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR = sram_addr_r;
  assign SRAM_WE_N = we_n_r;
  assign rd_data   = rd_data_r;
  assign ready     = ready_s;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed table, corner sequences, random traffic.
module tb_sram_controller;
  localparam int W    = 2;
  localparam int BASE = 1024;

  logic        clk, rst, rd_en, wr_en;
  logic [31:0] address, wr_data;
  logic [31:0] rd_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;
`ifdef SRAM_CTRL_PERF_CNT_EN
  logic [31:0] rd_count, wr_count, stall_count;
`endif

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N)
`ifdef SRAM_CTRL_PERF_CNT_EN
    , .rd_count(rd_count), .wr_count(wr_count), .stall_count(stall_count)
`endif
  );

  // Behavioural async SRAM: chip always enabled, drives the bus whenever not written.
  bit [15:0] sram_mem [262144];
  assign SRAM_DQ = SRAM_WE_N ? sram_mem[SRAM_ADDR] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;

  // Reference model: word-addressed memory plus last load result.
  bit [31:0] ref_mem [131072];
  bit [31:0] last_rd;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'd1024;
    return 17'((off / 32'd4) % 32'd131072);
  endfunction

  // One full access from an IDLE negedge; returns at the negedge after the following IDLE cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [16:0] word, input logic [31:0] exp_rd, input string tag);
    rd_en = rd; wr_en = wr; address = addr; wr_data = wd;
    #1 chk({tag, " idle_ready"}, 32'(ready), 32'd0);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0; address = $urandom; wr_data = $urandom;
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < W; c++) begin
        @(negedge clk);
        chk({tag, " sram_addr"}, 32'(SRAM_ADDR), 32'(word) * 32'd2 + 32'(ph));
        chk({tag, " we_n"}, 32'(SRAM_WE_N), wr ? 32'd0 : 32'd1);
        chk({tag, " ready_low"}, 32'(ready), 32'd0);
        if (wr) chk({tag, " dq"}, 32'(SRAM_DQ), (wd >> (16 * ph)) & 32'h0000FFFF);
      end
    end
    @(negedge clk);
    chk({tag, " done_ready"}, 32'(ready), 32'd1);
    chk({tag, " done_we_n"}, 32'(SRAM_WE_N), 32'd1);
    chk({tag, " done_rd_data"}, rd_data, exp_rd);
    @(negedge clk);
    chk({tag, " idle_ready_after"}, 32'(ready), 32'd1);
    chk({tag, " hold_rd_data"}, rd_data, exp_rd);
    chk({tag, " hold_addr"}, 32'(SRAM_ADDR), 32'(word) * 32'd2 + 32'd1);
    if (wr) ref_mem[word] = wd;
    else last_rd = ref_mem[word];
  endtask

  // Random or model-driven access: expectations come from the reference model.
  task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, input string tag);
    logic [16:0] w;
    w = word_of(addr);
    access(rd, wr, addr, wd, w, wr ? last_rd : ref_mem[w], tag);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [16:0] word;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int ready_low_cnt, done_cnt;
    logic [31:0] pre_rd, pre_stall;

    vecs[0] = '{rd:1'b0, wr:1'b1, addr:32'd1024, wdata:32'hDEADBEEF, word:17'd0,       exp_rd:32'h0,        name:"st1024"};
    vecs[1] = '{rd:1'b1, wr:1'b0, addr:32'd1024, wdata:32'h0,        word:17'd0,       exp_rd:32'hDEADBEEF, name:"ld1024"};
    vecs[2] = '{rd:1'b1, wr:1'b1, addr:32'd1040, wdata:32'h12345678, word:17'd4,       exp_rd:32'hDEADBEEF, name:"both1040"};
    vecs[3] = '{rd:1'b1, wr:1'b0, addr:32'd1040, wdata:32'h0,        word:17'd4,       exp_rd:32'h12345678, name:"ld1040"};
    vecs[4] = '{rd:1'b1, wr:1'b0, addr:32'd1036, wdata:32'h0,        word:17'd3,       exp_rd:32'h0,        name:"ld1036"};
    vecs[5] = '{rd:1'b1, wr:1'b0, addr:32'd1020, wdata:32'h0,        word:17'h1FFFF,   exp_rd:32'h0,        name:"ld1020"};
    vecs[6] = '{rd:1'b0, wr:1'b1, addr:32'd1020, wdata:32'hA5A55A5A, word:17'h1FFFF,   exp_rd:32'h0,        name:"st1020"};
    vecs[7] = '{rd:1'b1, wr:1'b0, addr:32'd1020, wdata:32'h0,        word:17'h1FFFF,   exp_rd:32'hA5A55A5A, name:"ld1020b"};

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; wr_data = 32'd0;
    last_rd = 32'd0;
    #12;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset we_n", 32'(SRAM_WE_N), 32'd1);
    chk("reset sram_addr", 32'(SRAM_ADDR), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
`ifdef SRAM_CTRL_PERF_CNT_EN
    chk("reset stall_count", stall_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].word, vecs[i].exp_rd, vecs[i].name);

    // Reset during HIGH of a write: low half lands, high half keeps its old value.
    model_access(1'b0, 1'b1, 32'd1044, 32'h11112222, "pre_st1044");
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1044; wr_data = 32'h33334444;
    @(posedge clk); #1;
    wr_en = 1'b0;
    for (int c = 0; c < W + 1; c++) @(negedge clk);
    chk("mid high addr", 32'(SRAM_ADDR), 32'd11);
    chk("mid high we_n", 32'(SRAM_WE_N), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[5] = (ref_mem[5] & 32'hFFFF0000) | 32'h00004444;
    @(negedge clk);
    access(1'b1, 1'b0, 32'd1044, 32'h0, 17'd5, 32'h11114444, "ld_partial");

    // rd_en held for 12 cycles: exactly two loads, each with a single DONE cycle.
`ifdef SRAM_CTRL_PERF_CNT_EN
    pre_rd = rd_count; pre_stall = stall_count;
`else
    pre_rd = 32'd0; pre_stall = 32'd0;
`endif
    ready_low_cnt = 0; done_cnt = 0;
    rd_en = 1'b1; address = 32'd1044;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (ready) done_cnt++;
      else ready_low_cnt++;
    end
    @(negedge clk);
    rd_en = 1'b0;
    last_rd = ref_mem[5];
    chk("b2b ready_low_cycles", 32'(ready_low_cnt), 32'd10);
    chk("b2b done_cycles", 32'(done_cnt), 32'd2);
    chk("b2b rd_data", rd_data, 32'h11114444);
`ifdef SRAM_CTRL_PERF_CNT_EN
    chk("b2b rd_count", rd_count - pre_rd, 32'd2);
    chk("b2b stall_count", stall_count - pre_stall, 32'd10);
`else
    chk("b2b no_counter_baseline", pre_rd + pre_stall, 32'(ready_low_cnt - 10 + done_cnt - 2));
`endif
    @(negedge clk);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'(BASE) + 32'd4 * 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      model_access(op != 2, op >= 2, a, $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
